// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response bus between core and data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with word-addressed RAM
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_responder_if.slave         bus,
    output logic                    busy,
    output logic [15:0]             txn_count
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $fatal(1, "dmem_responder: LATENCY=%0d outside 1..15", LATENCY);
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    logic              acc_err;
    logic              commit;
    logic [ADDR_W-1:0] word;

    assign acc_err = (cap_addr[1:0] != 2'b00) || (cap_addr[31:ADDR_W+2] != '0);
    assign word    = cap_addr[ADDR_W+1:2];
    assign commit  = (state == ST_WAIT) && (cnt == 4'd0);

    // RAM is deliberately outside the reset domain; a reset before commit suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && commit && cap_we && !acc_err) begin
            mem[word] <= cap_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= 4'd0;
            cap_we         <= 1'b0;
            cap_addr       <= '0;
            cap_wdata      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            busy           <= 1'b0;
            txn_count      <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cap_we        <= bus.req_we;
                        cap_addr      <= bus.req_addr;
                        cap_wdata     <= bus.req_wdata;
                        cnt           <= LAT_M1;
                        state         <= ST_WAIT;
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state          <= ST_RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= acc_err;
                        bus.resp_rdata <= (acc_err || cap_we) ? 32'd0 : mem[word];
                    end
                end
                ST_RESP: begin
                    state          <= ST_IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    busy           <= 1'b0;
                    txn_count      <= txn_count + 16'd1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] txn_count;

    int          checks;
    int          failures;
    logic [15:0] exp_cnt;
    logic [31:0] rd;
    logic        er;

    dmem_responder_if bus ();

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .txn_count (txn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after a rising edge with the responder idle; checks the LATENCY=2 timeline.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        chk("ready_pre", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        step();
        bus.req_valid = 1'b0;
        chk("busy_k", 32'(busy), 32'd1);
        chk("ready_k", 32'(bus.req_ready), 32'd0);
        chk("rv_k", 32'(bus.resp_valid), 32'd0);
        step();
        chk("rv_k1", 32'(bus.resp_valid), 32'd0);
        step();
        chk("rv_k2", 32'(bus.resp_valid), 32'd1);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("rv_k3", 32'(bus.resp_valid), 32'd0);
        chk("ready_k3", 32'(bus.req_ready), 32'd1);
        chk("busy_k3", 32'(busy), 32'd0);
        chk("txn_count", 32'(txn_count), 32'(exp_cnt));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        exp_cnt       = 16'd0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        step();
        step();
        chk("rst_rv", 32'(bus.resp_valid), 32'd0);
        rst = 1'b1;
        step();
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rv", 32'(bus.resp_valid), 32'd0);
        chk("idle_cnt", 32'(txn_count), 32'd0);
        chk("idle_rdata", bus.resp_rdata, 32'd0);
        chk("idle_err", 32'(bus.resp_err), 32'd0);

        do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, er);
        chk("st10_err", 32'(er), 32'd0);
        chk("st10_rdata", rd, 32'd0);
        do_txn(1'b0, 32'h0000_0010, 32'h0, rd, er);
        chk("ld10_rdata", rd, 32'hDEAD_BEEF);
        chk("ld10_err", 32'(er), 32'd0);
        chk("ld10_cnt2", 32'(txn_count), 32'd2);

        do_txn(1'b1, 32'h0000_0000, 32'h0BAD_F00D, rd, er);
        do_txn(1'b0, 32'h0000_0013, 32'h0, rd, er);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rdata", rd, 32'd0);
        do_txn(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        do_txn(1'b0, 32'h0000_0000, 32'h0, rd, er);
        chk("w0_rdata", rd, 32'h0BAD_F00D);
        chk("w0_err", 32'(er), 32'd0);

        // Inputs churn after acceptance; a load is held valid through RESP.
        do_txn(1'b1, 32'h0000_0044, 32'h5555_AAAA, rd, er);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'hA5A5_0001;
        step();
        chk("stab_busy", 32'(busy), 32'd1);
        bus.req_addr  = 32'h0000_0044;
        bus.req_wdata = 32'h1111_1111;
        step();
        bus.req_addr  = 32'h0000_0048;
        bus.req_wdata = 32'h2222_2222;
        step();
        chk("stab_rv", 32'(bus.resp_valid), 32'd1);
        chk("stab_err", 32'(bus.resp_err), 32'd0);
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'h3333_3333;
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("stab_idle_rv", 32'(bus.resp_valid), 32'd0);
        chk("stab_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("stab_cnt1", 32'(txn_count), 32'(exp_cnt));
        step();
        bus.req_valid = 1'b0;
        chk("b2b_accept_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        step();
        chk("b2b_rv_k1", 32'(bus.resp_valid), 32'd0);
        step();
        chk("b2b_rv", 32'(bus.resp_valid), 32'd1);
        chk("b2b_rdata", bus.resp_rdata, 32'hA5A5_0001);
        step();
        exp_cnt = exp_cnt + 16'd1;
        chk("b2b_cnt", 32'(txn_count), 32'(exp_cnt));
        chk("b2b_no_dup", 32'(busy), 32'd0);
        do_txn(1'b0, 32'h0000_0044, 32'h0, rd, er);
        chk("stab_w44", rd, 32'h5555_AAAA);

        do_txn(1'b1, 32'h0000_0020, 32'h0000_0000, rd, er);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        bus.req_wdata = 32'h1234_5678;
        step();
        bus.req_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_cnt = 16'd0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_rst_cnt", 32'(txn_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_rst_no_rv", 32'(bus.resp_valid), 32'd0);
            step();
        end
        do_txn(1'b0, 32'h0000_0020, 32'h0, rd, er);
        chk("mid_rst_w20", rd, 32'h0000_0000);

        force dut.txn_count = 16'hFFFF;
        #1;
        release dut.txn_count;
        exp_cnt = 16'hFFFF;
        chk("wrap_pre", 32'(txn_count), 32'h0000_FFFF);
        #3;
        step();
        do_txn(1'b0, 32'h0000_0010, 32'h0, rd, er);
        chk("wrap_zero", 32'(txn_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the processor's load/store interface.
- The core (initiator) raises a read or write request with a valid/ready handshake.
- This block accepts the request, waits a fixed number of cycles, performs the access on an internal word-addressed RAM, and returns a one-cycle response with read data and an error flag.
- It replaces the zero-latency memory so the core can be brought up against realistic wait states.

Parameters:
- ADDR_W, 10, word-address width; RAM holds 2**ADDR_W 32-bit words (byte range 0 .. 4*2**ADDR_W-1).
- LATENCY, 2, wait cycles between accept and response; legal range 1..15, and 0 is unsupported.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- req_valid  input  1  initiator has a request.
- req_ready  output  1  responder can accept.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data (0 on store or error).
- resp_err  output  1  misaligned or out-of-range access, valid with resp_valid.
- busy  output  1  transaction in flight (state != IDLE).
- txn_count  output  16  completed responses, wraps at 16'hFFFF -> 0.

Behaviour:
- FSM states are IDLE, WAIT, RESP. Encoding is free.
- Reset (rst=0 at a clk edge):
  - state goes to IDLE, the internal counter to 0, and the captured request registers to 0.
  - Outputs: req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_err=0, busy=0, txn_count=0.
  - RAM contents are NOT reset.
- Reset has priority over every other event.
- Handshake: a request is accepted at a rising edge where state=IDLE and req_valid=1 (req_ready is 1 only in IDLE).
- On acceptance, req_we, req_addr and req_wdata are captured. Input changes after the accept edge are ignored.
- Accept edge: IDLE -> WAIT, with the counter loaded to LATENCY-1.
- In WAIT, when the counter is not 0, the counter decrements each edge.
- In WAIT, when the counter is 0, the next edge goes to RESP, and at that same edge the access commits:
  - Error check: err = (addr[1:0] != 0) or (addr[31:ADDR_W+2] != 0).
  - Load, no error: resp_rdata <= RAM[addr[ADDR_W+1:2]], resp_err <= 0.
  - Store, no error: RAM[word] <= wdata, resp_rdata <= 0, resp_err <= 0.
  - Any error: RAM is unchanged, resp_rdata <= 0, resp_err <= 1.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - The next edge goes to IDLE, sets resp_valid to 0, and increments txn_count; error responses are counted too.
  - resp_rdata and resp_err hold their values until the next commit or reset.
- Latency: accept at edge k gives resp_valid=1 in the cycle after edge k+LATENCY. req_ready returns to 1 in the cycle after edge k+LATENCY+1.
- Throughput: one transaction per LATENCY+2 cycles.
- Back-to-back: a request held valid through RESP is accepted at the first edge where state=IDLE. No request is ever dropped or duplicated.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Reset mid-operation:
  - Reset in IDLE or WAIT (before the commit edge): no RAM write occurs and no response is issued.
  - Reset in RESP: the commit already happened, resp_valid is cleared, and txn_count is cleared, not incremented.
- req_valid in WAIT or RESP has no effect.
- LATENCY=0 is outside the legal range. Simulation must flag it with a fatal error at time 0.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> req_ready=1, busy=0, resp_valid=0, txn_count=0.
- Store then load, LATENCY=2:
  - Store addr=0x0000_0010, wdata=0xDEAD_BEEF, accepted at edge k -> resp_valid high only in the cycle after edge k+2, resp_err=0.
  - Load addr=0x10 -> resp_rdata=0xDEAD_BEEF, txn_count=2.
- Errors:
  - Load addr=0x0000_0013 (misaligned) -> resp_err=1, resp_rdata=0.
  - Store addr=0x0000_1000 with ADDR_W=10 (out of range) -> resp_err=1.
  - A following load of word 0 returns its prior contents unchanged.
- Handshake stability: change req_addr/req_wdata every cycle after acceptance and hold req_valid=1 continuously -> the captured values are used, and the second request is accepted exactly at the edge after RESP.
- Reset mid-transaction: accept a store to 0x20 (data 0x1234_5678), assert rst during WAIT -> no resp_valid. A later load from 0x20 returns the previously written value (0x0000_0000 if the bench pre-wrote 0).
- Counter wrap: preload via 65,536 completed transactions (or force txn_count=16'hFFFF) -> the next response wraps it to 0.
